// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state codes, handshake levels and bus widths for the divider
package div_unit_pkg;
   localparam logic [1:0] DIV_FREE    = 2'b00;
   localparam logic [1:0] DIV_BY_ZERO = 2'b01;
   localparam logic [1:0] DIV_ON      = 2'b10;
   localparam logic [1:0] DIV_END     = 2'b11;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START = 1'b1;
   localparam int REG_BUS = 32;
endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division iteration
module div_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dsr_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);
   logic [WIDTH:0] sh;
   // shifted remainder is WIDTH+1 bits wide so the compare never drops the top carry
   always_comb begin
      sh    = {rem_i, bit_i};
      q_o   = sh >= {1'b0, dsr_i};
      rem_o = sh[WIDTH-1:0] - (q_o ? dsr_i : '0);
   end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = REG_BUS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d, dvd_q, dvd_d, dsr_q, dsr_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d, ready_q, ready_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0]   step_rem, quo, abs1, abs2;
   logic               qbit, last;
   div_unit_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .dsr_i (dsr_q),
      .bit_i (dvd_q[WIDTH-1]),
      .rem_o (step_rem),
      .q_o   (qbit)
   );
   // operand magnitudes, the quotient after this step, and the final-iteration flag
   always_comb begin
      abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      quo  = {dvd_q[WIDTH-2:0], qbit};
      last = cnt_q == CW'(WIDTH - 1);
   end
   // divider FSM: accept, iterate, sign-fix and hold the result until start drops
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      ready_d  = DIV_RESULT_NOT_READY;
      result_d = result_q;
      case (state_q)
         DIV_FREE: begin
            result_d = '0;
            if (start_i == DIV_START && !annul_i) begin
               state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
               cnt_d   = '0;
               rem_d   = '0;
               dvd_d   = abs1;
               dsr_d   = abs2;
               qneg_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               rneg_d  = signed_div_i & opdata1_i[WIDTH-1];
            end
         end
         DIV_BY_ZERO: begin
            state_d  = annul_i ? DIV_FREE : DIV_END;
            result_d = '0;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_d = DIV_FREE;
            end else begin
               rem_d = step_rem;
               dvd_d = quo;
               cnt_d = cnt_q + CW'(1);
               if (last) begin
                  state_d  = DIV_END;
                  ready_d  = DIV_RESULT_READY;
                  result_d = {rneg_q ? -step_rem : step_rem, qneg_q ? -quo : quo};
               end
            end
         end
         default: begin
            ready_d  = start_i;
            state_d  = start_i ? DIV_END : DIV_FREE;
            result_d = start_i ? result_q : '0;
         end
      endcase
   end
   // state registers with synchronous reset overriding every input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         ready_q  <= DIV_RESULT_NOT_READY;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end
   assign result_o = result_q;
   assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and sequence checks of the iterative divider
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst, signed_div_i, start_i, annul_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // n counts rising edges after the edge that samples start; operands are scrambled after it
   task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res, input int lat,
                          input int hold);
      int   n;
      logic seen;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      n    = -1;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 0) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
         seen = ready_o;
      end
      chk({name, " latency"}, 64'(n), 64'(lat));
      chk({name, " result"}, result_o, res);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, " hold ready"}, 64'(ready_o), 64'd1);
         chk({name, " hold result"}, result_o, res);
      end
      start_i = 1'b0;
      @(negedge clk);
      chk({name, " drop ready"}, 64'(ready_o), 64'd0);
      chk({name, " drop result"}, result_o, 64'd0);
   endtask

   initial begin
      logic rose;
      vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 32, 0};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, 6};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 32, 0};
      vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 32, 0};
      vecs[4] = '{1'b0, 32'd12345,      32'd0,        64'd0,                        2,  0};
      vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd3,        {32'h00000000, 32'h55555555}, 32, 0};
      vecs[6] = '{1'b0, 32'd5,          32'd9,        {32'h00000005, 32'h00000000}, 32, 0};
      vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 32, 0};
      vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 32, 0};
      vecs[9] = '{1'b1, 32'hFFFFFFF8,   32'd0,        64'd0,                        2,  0};

      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                 vecs[i].res, vecs[i].lat, vecs[i].hold);

      // annul at iteration 10, then a fresh division
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'hFFFFFFFF;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      rose = 1'b0;
      for (int n = -1; n < 10; n++) begin
         @(negedge clk);
         rose |= ready_o;
      end
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul ready", 64'(ready_o), 64'd0);
      chk("annul result", result_o, 64'd0);
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         rose |= ready_o;
      end
      chk("annul never ready", 64'(rose), 64'd0);
      run_div("restart 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 0);

      // annul while in FREE blocks the start
      @(negedge clk);
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i = 1'b1;
      annul_i = 1'b1;
      rose = 1'b0;
      repeat (4) begin
         @(negedge clk);
         rose |= ready_o;
      end
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (36) begin
         @(negedge clk);
         rose |= ready_o;
      end
      chk("annul in free", 64'(rose), 64'd0);

      // annul while in BY_ZERO returns to FREE
      @(negedge clk);
      opdata1_i = 32'd1;
      opdata2_i = 32'd0;
      start_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      rose = 1'b0;
      repeat (5) begin
         @(negedge clk);
         rose |= ready_o;
      end
      chk("annul by zero", 64'(rose), 64'd0);

      // reset mid-iteration with start still asserted
      @(negedge clk);
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst mid ready", 64'(ready_o), 64'd0);
      chk("rst mid result", result_o, 64'd0);
      @(negedge clk);
      chk("rst over start", 64'(ready_o), 64'd0);
      rst = 1'b0;
      start_i = 1'b0;
      rose = 1'b0;
      repeat (40) begin
         @(negedge clk);
         rose |= ready_o;
      end
      chk("rst no finish", 64'(rose), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider serving MIPS DIV/DIVU in the EX stage.
- Produces {remainder, quotient} as a 64-bit result; MEM/WB then writes it into the HI/LO register pair (HI = remainder, LO = quotient).
- ready_o is the EX-stage stall-release signal: the pipeline stalls while a division is in flight.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high (sampled on rising clk; the codebase compares against `RstEnable)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  cancel in-flight division (exception/flush)
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  out  1  result_o valid

Behaviour:
- Reset: state = FREE, result_o = 0, ready_o = 0, internal counter/dividend registers = 0. Reset overrides all inputs, including mid-operation.
- FSM states: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i = 1, annul_i = 0, opdata2_i = 0 → BY_ZERO.
  - start_i = 1, annul_i = 0, opdata2_i ≠ 0 → ON. Latch operands, taking absolute values when signed_div_i = 1. Counter = 0. Also latch the sign of the dividend and sign(dividend) XOR sign(divisor).
  - Otherwise → stay in FREE. ready_o = 0, result_o = 0.
- BY_ZERO: next edge → END with result_o = 0 (decided value for divide by zero).
- ON, per edge:
  - annul_i = 1 → FREE immediately; ready_o stays 0; result_o stays 0.
  - Otherwise perform one restoring step: shift the partial remainder left, bringing in the next dividend bit. Compute a WIDTH+1-bit difference = partial remainder − divisor. If non-negative, keep the difference and shift in quotient bit 1; else keep the partial remainder and shift in 0. Counter++.
  - On the edge completing iteration WIDTH: apply the sign fix-up (signed only). Quotient is negated if the sign XOR is set; remainder is negated if the dividend was negative. Register result_o and go → END.
- END:
  - ready_o = 1 and result_o is held stable.
  - start_i = 0 → FREE on the next edge, with ready_o = 0 and result_o = 0 after that edge.
  - start_i stays 1 → remain in END.
- Latency, measured from the edge E0 that samples start_i in FREE:
  - nonzero divisor: ready_o high after edge E0 + WIDTH, i.e. 32 cycles for WIDTH = 32.
  - zero divisor: ready_o high after E0 + 2.
- Operand changes on opdata*_i after E0 are ignored; operands are latched.
- annul_i in FREE blocks the start. annul_i in BY_ZERO → FREE. annul_i in END is ignored; the result is already committed.
- Signed overflow case, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 (natural two's-complement wrap, no trap).
- Width rules: the divisor compare uses WIDTH+1 bits so no carry is lost. Absolute value of 0x80000000 is treated as unsigned 2^31.
- Simultaneous start_i and rst: rst wins.

Decomposition:
- Shared defines (defines.v):
  - DivFree/DivByZero/DivOn/DivEnd (2-bit state codes)
  - DivResultReady/DivResultNotReady
  - DivStart/DivStop
  - RegBus, DoubleRegBus
  - ZeroWord, DoubleZeroWord
- Sub-module: div_step, a combinational single restoring iteration with WIDTH+1-bit subtract. Inputs: partial remainder, divisor, next bit. Outputs: new remainder, quotient bit.

Test Plan:
- DIVU 100 / 7 → ready_o after 32 cycles; result_o = {0x00000002, 0x0000000E}.
- DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}, no hang.
- Any dividend / 0 → ready_o exactly 2 cycles after start sampled; result_o = 0; start_i dropped → FREE, ready_o = 0 next cycle.
- annul_i pulsed at iteration 10 of 0xFFFFFFFF/3 → FREE next edge, ready_o never rises. Immediate re-start 9/3 → {0, 3} after 32 cycles.
- rst asserted mid-ON → all outputs 0 on next edge. start_i held high through END → ready_o and result_o stay constant for 5+ cycles.
